// File: rtl/ccff_pkg.sv
// Shared types and CRC helper for the configuration-chain bitstream loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_e;

  localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
  localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

  // One MSB-first serial step of CRC-16-CCITT.
  function automatic logic [15:0] ccff_crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_tail_crc16.sv
// Serial CRC-16 accumulator over the bits displaced from the chain tail.
module ccff_tail_crc16
  import ccff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) crc <= CCFF_CRC_INIT;
    else if (en)    crc <= ccff_crc16_step(crc, din);
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration words MSB-first into ccff_head with a per-bit shift
// enable, and signs the displaced tail bits with a CRC-16.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tail_crc
);

  localparam int          WL_W      = $clog2(WORD_W + 1);
  localparam logic [31:0] CHAIN_LEN_U = 32'(CHAIN_LEN);

  ccff_state_e       state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WL_W-1:0]   word_left;
  logic [WORD_W-1:0] sreg;

  logic        shifting;
  logic        accept;
  logic        last_bit;
  logic        crc_clr;
  logic [31:0] committed;

  assign shifting  = (state == LOAD) && (word_left != '0);
  // Bits already shifted plus bits still queued in sreg; no new word once this covers the chain.
  assign committed = 32'(bit_cnt) + 32'(word_left);
  assign s_ready   = (state == LOAD)
                   && ((word_left == '0) || ((word_left == WL_W'(1)) && shifting))
                   && (committed < CHAIN_LEN_U);
  assign accept    = s_valid && s_ready;
  assign last_bit  = shifting && ((32'(bit_cnt) + 32'd1) == CHAIN_LEN_U);
  assign crc_clr   = (state == IDLE) && start;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_left     <= '0;
      sreg          <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      ccff_shift_en <= shifting;
      done          <= 1'b0;

      if (shifting) begin
        ccff_head <= sreg[WORD_W-1];
        sreg      <= sreg << 1;
        bit_cnt   <= bit_cnt + CNT_W'(1);
        // A final partial word drops its low bits once the chain is full.
        word_left <= last_bit ? '0 : word_left - WL_W'(1);
      end

      // Overrides the shift update so the next word follows with no bubble.
      if (accept) begin
        sreg      <= s_data;
        word_left <= WL_W'(WORD_W);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            word_left <= '0;
            sreg      <= '0;
          end
        end
        LOAD: begin
          if (32'(bit_cnt) == CHAIN_LEN_U) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ccff_tail_crc16 u_crc (
    .clk (prog_clk),
    .rst (prog_reset),
    .clr (crc_clr),
    .en  (ccff_shift_en),
    .din (ccff_tail),
    .crc (tail_crc)
  );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench: a 64-flop and a 40-flop chain loader, behavioural chain model, head scoreboard.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start64, sv64, rdy64, head64, en64, busy64, done64, tail64;
  logic [31:0] sd64;
  logic [15:0] crc64;
  logic        start40, sv40, rdy40, head40, en40, busy40, done40, tail40;
  logic [31:0] sd40;
  logic [15:0] crc40;

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(64)) u64 (
    .prog_clk(clk), .prog_reset(rst), .start(start64), .s_data(sd64), .s_valid(sv64),
    .s_ready(rdy64), .ccff_head(head64), .ccff_shift_en(en64), .ccff_tail(tail64),
    .busy(busy64), .done(done64), .tail_crc(crc64));

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(40)) u40 (
    .prog_clk(clk), .prog_reset(rst), .start(start40), .s_data(sd40), .s_valid(sv40),
    .s_ready(rdy40), .ccff_head(head40), .ccff_shift_en(en40), .ccff_tail(tail40),
    .busy(busy40), .done(done40), .tail_crc(crc40));

  // Behavioural 64-flop chain, preloaded with zeros and never reset.
  logic [63:0] chain = '0;
  always @(posedge clk) if (en64) chain <= {chain[62:0], head64};
  assign tail64 = chain[63];
  assign tail40 = 1'b0;

  int total = 0;
  int bad   = 0;
  bit sb64[$];
  bit sb40[$];
  logic [63:0] exp_chain = '0;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    bit          glitch;
    int          abort_at;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_bits(input logic [63:0] bits, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // cyc counts edges after start is sampled, the start edge being 1.
  task automatic run64(input vec_t v);
    logic [31:0] words[2];
    int wi, stall_left, cyc, en_cnt, gap, done_cnt, extra, pushed;
    logic last_head;
    logic [15:0] exp_crc;
    bit b;
    words[0] = v.w0; words[1] = v.w1;
    wi = 0; stall_left = v.stall; en_cnt = 0; gap = 0; done_cnt = 0; extra = 0; pushed = 0;
    exp_crc = crc_bits(exp_chain, 64);
    sb64.delete();
    @(negedge clk); start64 = 1'b1; sv64 = 1'b0;
    @(negedge clk); start64 = 1'b0; cyc = 1;
    chk("busy_after_start", busy64, 1);
    last_head = head64;
    while (cyc < v.exp_lat + 4) begin
      if (en64) begin
        if (sb64.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          b = sb64.pop_front();
          chk("head_bit", head64, b);
          exp_chain = {exp_chain[62:0], b};
        end
        en_cnt++;
        if (v.abort_at != 0 && en_cnt == v.abort_at) begin
          sv64 = 1'b0; rst = 1'b1;
          @(negedge clk); rst = 1'b0;
          chk("abort_ready", rdy64, 0);
          chk("abort_head", head64, 0);
          chk("abort_en", en64, 0);
          chk("abort_busy", busy64, 0);
          chk("abort_done", done64, 0);
          chk("abort_crc", crc64, 16'hFFFF);
          chk("abort_no_done", done_cnt, 0);
          return;
        end
      end else if (busy64 && en_cnt > 0 && en_cnt < 64) begin
        gap++;
        chk("head_hold", head64, last_head);
      end
      last_head = head64;
      if (done64) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("done_latency", cyc, v.exp_lat);
          chk("tail_crc", crc64, exp_crc);
        end
      end
      if (cyc > v.exp_lat) chk("busy_clear", busy64, 0);
      start64 = v.glitch && (cyc == 30 || cyc == v.exp_lat);
      if (wi < 2) begin
        if (wi == 1 && rdy64 && stall_left > 0) begin
          sv64 = 1'b0; stall_left--;
        end else begin
          sv64 = 1'b1; sd64 = words[wi];
        end
      end else begin
        sv64 = 1'b1; sd64 = 32'hFFFF_FFFF;
      end
      if (sv64 && rdy64) begin
        if (wi < 2) begin
          for (int i = 31; i >= 0; i--)
            if (pushed < 64) begin sb64.push_back(words[wi][i]); pushed++; end
          wi++;
        end else extra++;
      end
      @(negedge clk); cyc++;
    end
    sv64 = 1'b0; start64 = 1'b0;
    chk("en_count", en_cnt, 64);
    chk("stall_gap", gap, v.stall);
    chk("done_count", done_cnt, 1);
    chk("extra_accept", extra, 0);
    chk("sb_empty", sb64.size(), 0);
  endtask

  // Final partial word: only the top 8 bits of the second word reach the chain.
  task automatic run40();
    logic [31:0] words[2];
    int wi, cyc, en_cnt, done_cnt, extra, pushed;
    bit b;
    words[0] = 32'hFFFF_FFFF; words[1] = 32'hA500_0000;
    wi = 0; en_cnt = 0; done_cnt = 0; extra = 0; pushed = 0;
    sb40.delete();
    @(negedge clk); start40 = 1'b1; sv40 = 1'b0;
    @(negedge clk); start40 = 1'b0; cyc = 1;
    while (cyc < 47) begin
      if (en40) begin
        if (sb40.size() == 0) chk("sb40_underflow", 1, 0);
        else begin b = sb40.pop_front(); chk("head40_bit", head40, b); end
        en_cnt++;
      end
      if (done40) begin
        done_cnt++;
        chk("done40_latency", cyc, 43);
        chk("tail40_crc", crc40, crc_bits(64'd0, 40));
      end
      if (wi == 2) chk("ready40_low", rdy40, 0);
      sv40 = 1'b1;
      sd40 = (wi < 2) ? words[wi] : 32'h1234_5678;
      if (rdy40) begin
        if (wi < 2) begin
          for (int i = 31; i >= 0; i--)
            if (pushed < 40) begin sb40.push_back(words[wi][i]); pushed++; end
          wi++;
        end else extra++;
      end
      @(negedge clk); cyc++;
    end
    sv40 = 1'b0;
    chk("en40_count", en_cnt, 40);
    chk("accept40_count", wi, 2);
    chk("extra40_accept", extra, 0);
    chk("done40_count", done_cnt, 1);
  endtask

  initial begin
    vecs[0] = '{32'hDEADBEEF, 32'h01234567, 0, 1'b0, 0,  67};
    vecs[1] = '{32'h0F0F1234, 32'h80000001, 2, 1'b0, 0,  69};
    vecs[2] = '{32'hCAFEF00D, 32'h13579BDF, 0, 1'b1, 0,  67};
    vecs[3] = '{32'h5A5A5A5A, 32'hC3C3C3C3, 0, 1'b0, 20, 67};
    vecs[4] = '{32'h76543210, 32'hFEDCBA98, 0, 1'b0, 0,  67};

    rst = 1'b1;
    start64 = 1'b0; sv64 = 1'b0; sd64 = '0;
    start40 = 1'b0; sv40 = 1'b0; sd40 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready64", rdy64, 0);
    chk("rst_head64", head64, 0);
    chk("rst_en64", en64, 0);
    chk("rst_busy64", busy64, 0);
    chk("rst_done64", done64, 0);
    chk("rst_crc64", crc64, 16'hFFFF);
    chk("rst_ready40", rdy40, 0);
    chk("rst_en40", en40, 0);
    chk("rst_busy40", busy40, 0);
    chk("rst_crc40", crc40, 16'hFFFF);

    run40();
    for (int k = 0; k < 5; k++) run64(vecs[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Serializes configuration words into the configuration-chain head (`ccff_head`) of the tile column or row, and monitors what falls out of the far `ccff_tail`. It sits directly upstream of the first tile's `ccff_head` in the `prog_clk` domain. It issues a per-cycle shift enable so the chain advances only when a valid bit is presented. It also accumulates a CRC-16 over the displaced tail bits, giving a read-back signature of the previous configuration.

## Interface

Parameters:
- `WORD_W`, 32, width of an input configuration word.
- `CHAIN_LEN`, 1024, total flops in the downstream chain; must be ≥ 1.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, width of the bit counter (derived).

Ports:
- `prog_clk`  in  1  configuration clock; all logic is on the rising edge.
- `prog_reset`  in  1  reset: one clock, `prog_clk`; synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `s_data`  in  `WORD_W`  configuration word; MSB is shifted first.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  word accepted on a cycle where `s_valid && s_ready`.
- `ccff_head`  out  1  serial bit to the chain (registered).
- `ccff_shift_en`  out  1  chain clock-enable / gate; the chain shifts on edges where this is high.
- `ccff_tail`  in  1  chain output bit.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is exited.
- `done`  out  1  one-cycle pulse after the final bit has shifted.
- `tail_crc`  out  16  CRC-16-CCITT of the sampled tail bits; valid while `done` is high and held until the next `start`.

## Operation

States:
- IDLE → LOAD on `start`. On that edge: `bit_cnt`=0, `crc`=16'hFFFF, shift register empty.
- LOAD → DONE when `bit_cnt` reaches `CHAIN_LEN`.
- DONE → IDLE unconditionally on the next cycle; `done`=1 only in DONE.
- `start` in LOAD or DONE is ignored.

Shift register and input handshake:
- Shift register `sreg[WORD_W-1:0]` plus `word_left` (bits remaining, 0..`WORD_W`).
- `s_ready` = (state==LOAD) && (`word_left`==0 || (`word_left`==1 && shifting)) && (`bit_cnt` + `word_left` < `CHAIN_LEN`). This allows zero-bubble back-to-back words.
- Acceptance loads `sreg`←`s_data` and sets `word_left`=`WORD_W`.

Shifting and tail sampling:
- `shifting` = (state==LOAD) && `word_left`≠0.
- Each shifting cycle:
  - `ccff_head`←`sreg[WORD_W-1]`, `sreg`←`sreg`<<1, `word_left`−1, `bit_cnt`+1.
  - `ccff_shift_en` registered ←1. Otherwise `ccff_shift_en`←0 and `ccff_head` holds.
- Each cycle `ccff_shift_en`==1, `ccff_tail` is sampled into the CRC, MSB-first serial form: poly 0x1021, `fb = crc[15]^tail`, `crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0)`.

Final partial word:
- If `CHAIN_LEN % WORD_W` = r ≠ 0, only the top r bits of the final word are shifted.
- `bit_cnt` reaching `CHAIN_LEN` clears `word_left`; the remaining low bits are discarded.

Source stalls:
- When `s_valid` is low and `sreg` is empty, the chain pauses (`ccff_shift_en`=0). This is not an error.

Reset values (all outputs):
- State IDLE, `s_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `tail_crc`=16'hFFFF, `bit_cnt`=0, `word_left`=0.
- Reset mid-LOAD aborts without a `done` pulse. Chain contents are then undefined until a full reload.

## Timing

- `start` at edge t: `busy`=1 and `s_ready` may assert from cycle t+1.
- Word accepted at edge a: its MSB appears on `ccff_head` with `ccff_shift_en`=1 in cycle a+1.
- Continuous supply: exactly one bit per cycle with no gaps. The last bit is at cycle a0+`CHAIN_LEN`, where a0 is the first accept.
- `done` and final `tail_crc`: one cycle after the last enabled cycle (the CRC includes the last tail sample).
- Minimum total load latency: `CHAIN_LEN`+3 cycles from `start`.

## Structure

- Shared package `ccff_pkg`:
  - state enum (IDLE/LOAD/DONE);
  - `CCFF_CRC_POLY`=16'h1021;
  - `CCFF_CRC_INIT`=16'hFFFF;
  - a `ccff_crc16_step(crc, bit)` function.
- One natural sub-module: `ccff_tail_crc16`, the serial CRC accumulator with clear and enable. Everything else stays in the top module.

## Test plan

- `CHAIN_LEN`=64, `WORD_W`=32, always-valid words 32'hDEADBEEF, 32'h01234567 → 64 consecutive `ccff_shift_en` cycles; `ccff_head` stream equals the words MSB-first; `done` pulses once at `start`+67.
- `CHAIN_LEN`=40, words 32'hFFFFFFFF, 32'hA5000000 → 40 bits shifted; second word contributes 1010_0101; only two words accepted (`s_ready` low afterwards).
- `s_valid` toggled 1-0-0-1 between words → `ccff_shift_en` drops for exactly the starved cycles; `bit_cnt` and `ccff_head` hold; final stream unchanged.
- Behavioural chain model preloaded all-zeros, then reload: `tail_crc` equals the CRC of 64 zeros from 16'hFFFF. Second load with the chain holding the first pattern: `tail_crc` equals the CRC of that pattern.
- `prog_reset` asserted mid-LOAD at bit 20 → next cycle all outputs at reset values, no `done`. Subsequent `start` performs a full load.
- `start` asserted during LOAD and during DONE → ignored; exactly one `done` per accepted `start`.
